// File: rtl/interface_hcsr04_multi_pkg.sv
// Shared definitions for the multi-channel HC-SR04 interface.
// Holds the FSM state codes and the time-to-cycle conversion helpers.
package interface_hcsr04_multi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_TRIG      = 4'd1,
        ST_WAIT_ECHO = 4'd2,
        ST_MEASURE   = 4'd3,
        ST_STORE     = 4'd4,
        ST_TOUT      = 4'd5,
        ST_GAP       = 4'd6,
        ST_DONE      = 4'd7
    } state_t;

    // 64-bit arithmetic keeps CLK_HZ * us from overflowing at high clock rates
    function automatic longint us_to_cycles(input longint clk_hz, input longint us);
        return (us * clk_hz) / 64'd1_000_000;
    endfunction

    function automatic longint cycles_per_cm(input longint clk_hz);
        return (clk_hz * 64'd588235) / 64'd10_000_000_000;
    endfunction

endpackage

// File: rtl/contador_bcd_sat.sv
// Three-digit BCD up-counter with synchronous clear.
// Stops at 999 instead of wrapping so over-range echoes read as maximum distance.
module contador_bcd_sat (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [11:0] value
);

    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic       at_max;

    assign at_max = (dig2 == 4'd9) && (dig1 == 4'd9) && (dig0 == 4'd9);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dig0 <= 4'd0;
            dig1 <= 4'd0;
            dig2 <= 4'd0;
        end else if (clear) begin
            dig0 <= 4'd0;
            dig1 <= 4'd0;
            dig2 <= 4'd0;
        end else if (inc && !at_max) begin
            if (dig0 != 4'd9) begin
                dig0 <= dig0 + 4'd1;
            end else begin
                dig0 <= 4'd0;
                if (dig1 != 4'd9) begin
                    dig1 <= dig1 + 4'd1;
                end else begin
                    dig1 <= 4'd0;
                    dig2 <= dig2 + 4'd1;
                end
            end
        end
    end

    assign value = {dig2, dig1, dig0};

endmodule

// File: rtl/interface_hcsr04_multi.sv
// Sequential scanner for N_CH HC-SR04 sensors: one trigger at a time, echo width
// converted to rounded BCD centimetres, with a per-channel timeout flag.
module interface_hcsr04_multi
    import interface_hcsr04_multi_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int N_CH       = 2,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 25000,
    parameter int GAP_US     = 100,
    parameter int CYC_PER_CM = int'(cycles_per_cm(longint'(CLK_HZ)))
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 medir,
    input  logic [N_CH-1:0]      ch_enable,
    input  logic [N_CH-1:0]      echo,
    output logic [N_CH-1:0]      trigger,
    output logic [12*N_CH-1:0]   medida,
    output logic [N_CH-1:0]      timeout,
    output logic                 pronto,
    output logic                 busy,
    output logic [3:0]           db_estado,
    output logic [2:0]           db_canal
);

    localparam int TRIG_RAW = int'(us_to_cycles(longint'(CLK_HZ), longint'(TRIG_US)));
    localparam int TOUT_RAW = int'(us_to_cycles(longint'(CLK_HZ), longint'(TIMEOUT_US)));
    localparam int GAP_RAW  = int'(us_to_cycles(longint'(CLK_HZ), longint'(GAP_US)));
    localparam int TRIG_CYC = (TRIG_RAW < 1) ? 1 : TRIG_RAW;
    localparam int TOUT_CYC = (TOUT_RAW < 1) ? 1 : TOUT_RAW;
    localparam int GAP_CYC  = (GAP_RAW < 1) ? 1 : GAP_RAW;

    localparam int CNT_W  = $clog2(((TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC) + 1);
    localparam int TOUT_W = $clog2(TOUT_CYC + 1);
    localparam int CYC_W  = $clog2(CYC_PER_CM + 1);

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_CYC - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CYC_PER_CM - 1);
    localparam logic [CYC_W-1:0]  CYC_HALF  = CYC_W'(CYC_PER_CM / 2);

    state_t              state;
    logic [N_CH-1:0]     mask;
    logic [2:0]          ch;
    logic [CNT_W-1:0]    cnt;
    logic [TOUT_W-1:0]   tout_cnt;
    logic [CYC_W-1:0]    cyc_cnt;

    logic [N_CH-1:0]     echo_meta;
    logic [N_CH-1:0]     echo_s;
    logic [N_CH-1:0]     echo_d;

    logic                cur_echo;
    logic                cur_prev;
    logic                cur_rise;
    logic [2:0]          first_ch;
    logic [2:0]          next_ch;
    logic                next_ok;
    logic                tout_hit;
    logic                cyc_wrap;
    logic                bcd_clr;
    logic                bcd_inc;
    logic [11:0]         bcd_val;

    function automatic logic [N_CH-1:0] onehot(input logic [2:0] c);
        logic [N_CH-1:0] v;
        v = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (c == 3'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    // echo_d is one more stage so edges are seen on the already-synchronised signal
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_meta <= '0;
            echo_s    <= '0;
            echo_d    <= '0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    always_comb begin
        cur_echo = 1'b0;
        cur_prev = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == 3'(k)) begin
                cur_echo = echo_s[k];
                cur_prev = echo_d[k];
            end
        end
    end

    assign cur_rise = cur_echo & ~cur_prev;

    // Descending scan so the lowest qualifying channel is the one left standing
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        next_ok  = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (ch_enable[k]) first_ch = 3'(k);
            if (mask[k] && (3'(k) > ch)) begin
                next_ch = 3'(k);
                next_ok = 1'b1;
            end
        end
    end

    assign tout_hit = ((state == ST_WAIT_ECHO) || (state == ST_MEASURE)) && (tout_cnt == TOUT_LAST);
    assign cyc_wrap = (cyc_cnt == CYC_LAST);
    assign bcd_clr  = (state == ST_TRIG);

    // The rounding increment rides on the cycle that sees the echo fall
    always_comb begin
        bcd_inc = 1'b0;
        if (!tout_hit) begin
            case (state)
                ST_WAIT_ECHO: bcd_inc = cur_rise && cyc_wrap;
                ST_MEASURE:   bcd_inc = cur_echo ? cyc_wrap : (cyc_cnt >= CYC_HALF);
                default:      bcd_inc = 1'b0;
            endcase
        end
    end

    contador_bcd_sat u_bcd (
        .clock (clock),
        .reset (reset),
        .clear (bcd_clr),
        .inc   (bcd_inc),
        .value (bcd_val)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mask     <= '0;
            ch       <= '0;
            cnt      <= '0;
            tout_cnt <= '0;
            cyc_cnt  <= '0;
            trigger  <= '0;
            medida   <= '0;
            timeout  <= '0;
            pronto   <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (medir) begin
                        if (ch_enable != '0) begin
                            mask    <= ch_enable;
                            ch      <= first_ch;
                            trigger <= onehot(first_ch);
                            cnt     <= '0;
                            state   <= ST_TRIG;
                        end else begin
                            pronto <= 1'b1;
                        end
                    end
                end
                ST_TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        trigger  <= '0;
                        tout_cnt <= '0;
                        cyc_cnt  <= '0;
                        state    <= ST_WAIT_ECHO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_ECHO: begin
                    if (tout_hit) begin
                        state <= ST_TOUT;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                        if (cur_rise) begin
                            cyc_cnt <= cyc_wrap ? '0 : cyc_cnt + 1'b1;
                            state   <= ST_MEASURE;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (tout_hit) begin
                        state <= ST_TOUT;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                        if (cur_echo) begin
                            cyc_cnt <= cyc_wrap ? '0 : cyc_cnt + 1'b1;
                        end else begin
                            state <= ST_STORE;
                        end
                    end
                end
                ST_STORE: begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (ch == 3'(k)) begin
                            medida[12*k +: 12] <= bcd_val;
                            timeout[k]         <= 1'b0;
                        end
                    end
                    cnt   <= '0;
                    state <= ST_GAP;
                end
                ST_TOUT: begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (ch == 3'(k)) begin
                            medida[12*k +: 12] <= 12'h000;
                            timeout[k]         <= 1'b1;
                        end
                    end
                    cnt   <= '0;
                    state <= ST_GAP;
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (next_ok) begin
                            ch      <= next_ch;
                            trigger <= onehot(next_ch);
                            cnt     <= '0;
                            state   <= ST_TRIG;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    pronto <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign db_estado = state;
    assign db_canal  = ch;

endmodule
